// File: rtl/spi_master_shifter_if.sv
// Upstream/engine bundle for the SPI master shifter: control fields, tx/rx data and SPI pins.
// The engine uses the slave modport; the register block (or a bench) drives the master side.
interface spi_master_shifter_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  mstr;
    logic                  cpol;
    logic                  cpha;
    logic                  lsbfe;
    logic                  spiswai;
    logic [2:0]            sppr;
    logic [2:0]            spr;
    logic [1:0]            spi_mode;
    logic                  send_data;
    logic [DATA_WIDTH-1:0] mosi_data;
    logic                  miso;
    logic                  sclk;
    logic                  mosi;
    logic                  ss;
    logic                  tip;
    logic                  receive_data;
    logic [DATA_WIDTH-1:0] miso_data;

    modport master (
        output mstr, cpol, cpha, lsbfe, spiswai, sppr, spr, spi_mode, send_data, mosi_data, miso,
        input  sclk, mosi, ss, tip, receive_data, miso_data
    );

    modport slave (
        input  mstr, cpol, cpha, lsbfe, spiswai, sppr, spr, spi_mode, send_data, mosi_data, miso,
        output sclk, mosi, ss, tip, receive_data, miso_data
    );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI master transfer engine: one full-duplex byte per send_data pulse, baud set by sppr/spr.
// The tick ending LEAD is clock edge 1; edges 2..16 follow in XFER, then TRAIL ends the frame.
module spi_master_shifter #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 11
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    spi_master_shifter_if.slave   bus
);

    localparam int unsigned NumEdges = 2 * DATA_WIDTH;
    localparam int unsigned EdgeW    = $clog2(NumEdges + 1);

    typedef enum logic [1:0] {StIdle, StLead, StXfer, StTrail} state_e;

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [EdgeW-1:0]        edge_q, edge_d;
    logic                    sclk_q, sclk_d;
    logic [DATA_WIDTH-1:0]   tx_q, tx_d;
    logic [DATA_WIDTH-1:0]   rx_q, rx_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;
    logic                    cpha_q, cpha_d;
    logic                    lsbfe_q, lsbfe_d;
    logic [2:0]              sppr_q, sppr_d;
    logic [2:0]              spr_q, spr_d;

    logic                    start;
    logic                    abort;
    logic                    freeze;
    logic                    tick;
    logic [CNT_WIDTH-1:0]    half_m1;
    logic [EdgeW-1:0]        edge_next;
    logic                    sample_now;
    logic                    shift_now;
    logic                    last_edge;
    logic [DATA_WIDTH-1:0]   tx_shift;
    logic [DATA_WIDTH-1:0]   rx_shift;

    assign start  = bus.send_data && bus.mstr && (bus.spi_mode == 2'b00);
    assign abort  = !bus.mstr || bus.spi_mode[1];
    assign freeze = (bus.spi_mode == 2'b01) && bus.spiswai;

    // Half-period minus one, from the configuration latched at start.
    assign half_m1 = ((CNT_WIDTH'(sppr_q) + CNT_WIDTH'(1)) << spr_q) - CNT_WIDTH'(1);
    assign tick    = (cnt_q == half_m1);

    assign edge_next = edge_q + EdgeW'(1);
    assign last_edge = (edge_next == EdgeW'(NumEdges));

    // cpha=0: sample odd edges, shift on even ones except the last.
    // cpha=1: sample even edges, shift on odd ones except edge 1, which only exposes bit 0 of the frame.
    assign sample_now = cpha_q ? !edge_next[0] : edge_next[0];
    assign shift_now  = cpha_q ? (edge_next[0] && (edge_next != EdgeW'(1)))
                               : (!edge_next[0] && !last_edge);

    assign tx_shift = lsbfe_q ? {1'b0, tx_q[DATA_WIDTH-1:1]} : {tx_q[DATA_WIDTH-2:0], 1'b0};
    assign rx_shift = lsbfe_q ? {bus.miso, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], bus.miso};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        edge_d   = edge_q;
        sclk_d   = sclk_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        cpha_d   = cpha_q;
        lsbfe_d  = lsbfe_q;
        sppr_d   = sppr_q;
        spr_d    = spr_q;

        unique case (state_q)
            StIdle: begin
                sclk_d = bus.cpol;
                cnt_d  = '0;
                edge_d = '0;
                if (start) begin
                    tx_d    = bus.mosi_data;
                    rx_d    = '0;
                    cpha_d  = bus.cpha;
                    lsbfe_d = bus.lsbfe;
                    sppr_d  = bus.sppr;
                    spr_d   = bus.spr;
                    state_d = StLead;
                end
            end
            StLead, StXfer, StTrail: begin
                if (abort) begin
                    state_d = StIdle;
                    sclk_d  = bus.cpol;
                    cnt_d   = '0;
                    edge_d  = '0;
                end else if (!freeze) begin
                    if (!tick) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end else begin
                        cnt_d = '0;
                        if (state_q == StTrail) begin
                            state_d  = StIdle;
                            rvalid_d = 1'b1;
                            rdata_d  = rx_q;
                        end else begin
                            edge_d  = edge_next;
                            sclk_d  = ~sclk_q;
                            if (sample_now) rx_d = rx_shift;
                            if (shift_now)  tx_d = tx_shift;
                            state_d = last_edge ? StTrail : StXfer;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            edge_q   <= '0;
            sclk_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            cpha_q   <= 1'b0;
            lsbfe_q  <= 1'b0;
            sppr_q   <= '0;
            spr_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            sclk_q   <= sclk_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            cpha_q   <= cpha_d;
            lsbfe_q  <= lsbfe_d;
            sppr_q   <= sppr_d;
            spr_q    <= spr_d;
        end
    end

    assign bus.sclk         = sclk_q;
    assign bus.ss           = (state_q == StIdle);
    assign bus.tip          = (state_q != StIdle);
    assign bus.mosi         = (state_q != StIdle) &&
                              (lsbfe_q ? tx_q[0] : tx_q[DATA_WIDTH-1]);
    assign bus.receive_data = rvalid_q;
    assign bus.miso_data    = rdata_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: elapsed-time model of the SPI frame checked every cycle,
// a bit-serial slave on miso, and directed transfers with hand-computed latencies and data.
module tb_spi_master_shifter;

    logic PCLK = 1'b0;
    logic PRESET;

    spi_master_shifter_if bus ();

    spi_master_shifter dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    always #5 PCLK = ~PCLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] slave_byte = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a frame is 17 half-periods of unfrozen time after start; edge k lands at k*h.
    bit         m_valid = 0;
    bit         m_active = 0;
    int         m_e, m_h;
    logic       m_cpol, m_cpha, m_lsb;
    logic [7:0] m_tx, m_rx, m_md;
    logic       m_sclk, m_rv;

    function automatic int m_edges();
        int ed = m_e / m_h;
        return (ed > 16) ? 16 : ed;
    endfunction

    function automatic logic m_mosi();
        int ed = m_edges();
        int p;
        if (!m_cpha) p = ed / 2;
        else         p = (ed <= 1) ? 0 : (ed - 1) / 2;
        if (p > 7) p = 7;
        return m_lsb ? m_tx[p] : m_tx[7-p];
    endfunction

    always @(posedge PCLK) begin
        m_rv = 1'b0;
        if (PRESET) begin
            m_active = 0;
            m_sclk   = 1'b0;
            m_md     = 8'h00;
            m_valid  = 1;
        end else if (!m_active) begin
            m_sclk = bus.cpol;
            if (bus.send_data && bus.mstr && bus.spi_mode == 2'b00) begin
                m_active = 1;
                m_e      = 0;
                m_h      = (int'(bus.sppr) + 1) << bus.spr;
                m_cpol   = bus.cpol;
                m_cpha   = bus.cpha;
                m_lsb    = bus.lsbfe;
                m_tx     = bus.mosi_data;
                m_rx     = slave_byte;
            end
        end else if (!bus.mstr || bus.spi_mode[1]) begin
            m_active = 0;
            m_sclk   = bus.cpol;
        end else if (!(bus.spi_mode == 2'b01 && bus.spiswai)) begin
            m_e++;
            if (m_e == 17 * m_h) begin
                m_active = 0;
                m_rv     = 1'b1;
                m_md     = m_rx;
                m_sclk   = m_cpol;
            end
        end
        if (m_active) m_sclk = m_cpol ^ m_edges()[0];
    end

    always @(posedge PCLK) begin
        #1;
        if (m_valid) begin
            check("ss", bus.ss, !m_active);
            check("tip", bus.tip, m_active);
            check("sclk", bus.sclk, m_sclk);
            check("receive_data", bus.receive_data, m_rv);
            check("miso_data", bus.miso_data, m_md);
            if (m_active) check("mosi", bus.mosi, m_mosi());
        end
    end

    // Slave: present byte bit j once 2j clock edges have been seen in this frame.
    int   s_seen = 0;
    logic s_prev = 1'b0;
    always @(negedge PCLK) begin
        int j;
        if (bus.ss !== 1'b0) begin
            s_seen = 0;
            s_prev = bus.sclk;
        end else begin
            if (bus.sclk !== s_prev) s_seen++;
            s_prev = bus.sclk;
        end
        j = s_seen / 2;
        if (j > 7) j = 7;
        bus.miso = bus.lsbfe ? slave_byte[j] : slave_byte[7-j];
    end

    // kind: 0 none, 1 stop pulse, 2 wait freeze, 3 reset pulse, 4 stray send_data.
    // lat is cycles from the start sample to receive_data, -1 if none within max_cyc.
    task automatic run(input int kind, input int at, input int len, input int max_cyc,
                       output int lat, output logic [7:0] cap);
        int h;
        lat = -1;
        cap = 8'h00;
        h   = (int'(bus.sppr) + 1) << bus.spr;
        @(posedge PCLK); #1;
        bus.send_data = 1'b1;
        for (int n = 1; n <= max_cyc; n++) begin
            @(posedge PCLK); #1;
            if (n == 1) bus.send_data = 1'b0;
            if ((n - 1) % (2 * h) == 0 && (n - 1) < 16 * h) cap = {cap[6:0], bus.mosi};
            if (bus.receive_data) begin
                lat = n;
                break;
            end
            if (n == at) begin
                case (kind)
                    1: bus.spi_mode = 2'b10;
                    2: bus.spi_mode = 2'b01;
                    3: PRESET = 1'b1;
                    4: begin bus.send_data = 1'b1; bus.mosi_data = 8'hFF; end
                    default: ;
                endcase
            end
            if (n == at + len) begin
                bus.spi_mode  = 2'b00;
                PRESET        = 1'b0;
                bus.send_data = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        int         lat;
        logic [7:0] cap;
        PRESET        = 1'b1;
        bus.mstr      = 1'b1;
        bus.cpol      = 1'b0;
        bus.cpha      = 1'b0;
        bus.lsbfe     = 1'b0;
        bus.spiswai   = 1'b0;
        bus.sppr      = 3'd0;
        bus.spr       = 3'd0;
        bus.spi_mode  = 2'b00;
        bus.send_data = 1'b0;
        bus.mosi_data = 8'h00;
        repeat (3) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
        check("reset_ss", bus.ss, 1'b1);
        check("reset_tip", bus.tip, 1'b0);
        check("reset_sclk", bus.sclk, 1'b0);
        check("reset_mosi", bus.mosi, 1'b0);
        check("reset_rx_data", bus.miso_data, 8'h00);

        // Mode 0, MSB first, h=1.
        bus.mosi_data = 8'hA5;
        slave_byte    = 8'h3C;
        run(0, 0, 0, 40, lat, cap);
        check("m0_latency", lat, 18);
        check("m0_mosi_bits", cap, 8'hA5);
        check("m0_rx_byte", bus.miso_data, 8'h3C);

        // Mode 3, LSB first, h=8.
        bus.cpol = 1'b1; bus.cpha = 1'b1; bus.lsbfe = 1'b1;
        bus.sppr = 3'd1; bus.spr  = 3'd2;
        repeat (2) @(posedge PCLK);
        #1;
        check("m3_sclk_idle", bus.sclk, 1'b1);
        bus.mosi_data = 8'h81;
        slave_byte    = 8'h96;
        run(0, 0, 0, 200, lat, cap);
        check("m3_latency", lat, 137);
        check("m3_first_bit", cap[7], 1'b1);
        check("m3_rx_byte", bus.miso_data, 8'h96);

        // Stop abort mid-XFER, mode 0, h=2.
        bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsbfe = 1'b0;
        bus.sppr = 3'd1; bus.spr  = 3'd0;
        repeat (2) @(posedge PCLK);
        #1;
        bus.mosi_data = 8'h42;
        slave_byte    = 8'h11;
        run(1, 10, 1, 60, lat, cap);
        check("stop_no_receive", lat, -1);
        check("stop_rx_held", bus.miso_data, 8'h96);
        check("stop_tip", bus.tip, 1'b0);

        // Wait freeze of 20 cycles, h=2.
        bus.spiswai   = 1'b1;
        bus.mosi_data = 8'h3A;
        slave_byte    = 8'hE7;
        run(2, 12, 20, 100, lat, cap);
        check("wait_latency", lat, 55);
        check("wait_rx_byte", bus.miso_data, 8'hE7);
        bus.spiswai = 1'b0;

        // Stray send_data during a transfer, h=1.
        bus.sppr      = 3'd0;
        bus.mosi_data = 8'h5A;
        slave_byte    = 8'h69;
        run(4, 5, 1, 40, lat, cap);
        check("stray_latency", lat, 18);
        check("stray_mosi_bits", cap, 8'h5A);
        check("stray_rx_byte", bus.miso_data, 8'h69);

        // send_data with mstr=0 must not start anything.
        bus.mstr      = 1'b0;
        bus.send_data = 1'b1;
        @(posedge PCLK); #1;
        bus.send_data = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        check("nomstr_tip", bus.tip, 1'b0);
        check("nomstr_ss", bus.ss, 1'b1);
        bus.mstr = 1'b1;

        // Reset on the edge k=7 cycle, h=1.
        bus.mosi_data = 8'hC6;
        slave_byte    = 8'h0F;
        run(3, 7, 1, 40, lat, cap);
        check("reset_no_receive", lat, -1);
        check("reset_rx_cleared", bus.miso_data, 8'h00);

        // Mode 1, MSB first, h=4.
        bus.cpha      = 1'b1;
        bus.spr       = 3'd2;
        bus.mosi_data = 8'h6D;
        slave_byte    = 8'hB2;
        run(0, 0, 0, 100, lat, cap);
        check("m1_latency", lat, 69);
        check("m1_rx_byte", bus.miso_data, 8'hB2);

        repeat (3) @(posedge PCLK);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
